// File: rtl/sram_arbiter.sv
// Arbitrates one single-ported SRAM between instruction fetch and data access.
// Each access runs IDLE -> ACCESS (WAIT_CYCLES+1 cycles) -> DONE, with mem/if alternating under contention.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no access in flight; grant is evaluated from the live requests
// ACCESS | SRAM driven from latched request; wait counter runs down to 0
// DONE   | one-cycle ready pulse to the granted port; SRAM deselected
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_sel,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        sram_ce,
    output logic        sram_we,
    output logic [19:0] sram_addr,
    output logic [3:0]  sram_be,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        stall_req
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t     state;
    logic [1:0] cnt;
    logic       gnt_mem;
    logic       last_mem;
    logic       grant_mem;

    // mem wins contention unless it also won the previous grant
    assign grant_mem = mem_req & (~if_req | ~last_mem);

    assign stall_req = ~rst & ((if_req & ~if_ready) | (mem_req & ~mem_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            gnt_mem    <= 1'b0;
            last_mem   <= 1'b0;
            sram_ce    <= 1'b0;
            sram_we    <= 1'b0;
            sram_addr  <= 20'd0;
            sram_be    <= 4'd0;
            sram_wdata <= 32'd0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
            if_rdata   <= 32'd0;
            mem_rdata  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req | mem_req) begin
                        state    <= ACCESS;
                        cnt      <= 2'(WAIT_CYCLES);
                        gnt_mem  <= grant_mem;
                        last_mem <= grant_mem;
                        sram_ce  <= 1'b1;
                        if (grant_mem) begin
                            sram_we    <= mem_we;
                            sram_addr  <= mem_addr[21:2];
                            sram_be    <= mem_we ? mem_sel : 4'b1111;
                            sram_wdata <= mem_wdata;
                        end else begin
                            sram_we    <= 1'b0;
                            sram_addr  <= if_addr[21:2];
                            sram_be    <= 4'b1111;
                            sram_wdata <= 32'd0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == 2'd0) begin
                        state   <= DONE;
                        sram_ce <= 1'b0;
                        sram_we <= 1'b0;
                        if (gnt_mem) begin
                            mem_ready <= 1'b1;
                            if (!sram_we) mem_rdata <= sram_rdata;
                        end else begin
                            if_ready <= 1'b1;
                            if (!sram_we) if_rdata <= sram_rdata;
                        end
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    sram_ce   <= 1'b0;
                    sram_we   <= 1'b0;
                    if_ready  <= 1'b0;
                    mem_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have one parameter: WAIT_CYCLES, default 1, range 0..3, giving extra SRAM wait cycles per access.
REQ-002 The block SHALL have the following ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- if_req  in  1  instruction-fetch request.
- if_addr  in  32  fetch byte address.
- if_rdata  out  32  fetch read data.
- if_ready  out  1  fetch complete, one-cycle pulse.
- mem_req  in  1  data request.
- mem_we  in  1  data write (1) / read (0).
- mem_addr  in  32  data byte address.
- mem_wdata  in  32  data write value.
- mem_sel  in  4  data byte enables.
- mem_rdata  out  32  data read value.
- mem_ready  out  1  data access complete, one-cycle pulse.
- sram_ce  out  1  SRAM chip enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  20  SRAM word address.
- sram_be  out  4  SRAM byte enables.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data.
- stall_req  out  1  pipeline stall request.

Function
REQ-003 The FSM SHALL have three states: IDLE, ACCESS and DONE.
REQ-004 In IDLE with no request pending, the FSM SHALL stay in IDLE with sram_ce=0.
REQ-005 In IDLE with exactly one request pending, the FSM SHALL grant that requester.
REQ-006 In IDLE with both requests pending, the FSM SHALL grant mem unless the previous grant was mem, in which case it SHALL grant if.
REQ-007 On grant, the block SHALL latch the following and enter ACCESS with wait counter = WAIT_CYCLES:
- requester id;
- address bits [21:2];
- write flag (mem_we for mem, 0 for if);
- wdata;
- byte enables (mem_sel for a mem write, 4'b1111 otherwise).
REQ-008 In ACCESS, sram_ce=1 and sram_addr/sram_be/sram_wdata/sram_we SHALL be driven from the latched values, constant for all WAIT_CYCLES+1 ACCESS cycles.
REQ-009 In ACCESS, the counter SHALL decrement each cycle.
REQ-010 On the edge at which the counter is 0, the FSM SHALL go to DONE, and for a read SHALL capture sram_rdata into the granted port's rdata register.
REQ-011 In DONE, the granted port's ready SHALL be 1 for exactly one cycle, sram_ce SHALL be 0, and the next state SHALL be IDLE unconditionally.
REQ-012 Latency: a request sampled in IDLE at cycle 0 SHALL see ready=1 in cycle WAIT_CYCLES+2.
REQ-013 Throughput: one access SHALL complete per WAIT_CYCLES+3 cycles.
REQ-014 if_rdata and mem_rdata SHALL each hold their value until that port's next completed read.
REQ-015 A write SHALL NOT modify mem_rdata.
REQ-016 Deassertion of a request or changes to its inputs after grant SHALL NOT affect the access in flight; ready SHALL still pulse.
REQ-017 stall_req SHALL be combinational: (if_req AND NOT if_ready) OR (mem_req AND NOT mem_ready).
REQ-018 if_ready and mem_ready SHALL never be 1 in the same cycle.
REQ-019 sram_we SHALL never be 1 while sram_ce is 0.
REQ-020 Address bits [31:22] and [1:0] SHALL be ignored.
REQ-021 With WAIT_CYCLES=0, ACCESS SHALL last exactly one cycle.

Reset
REQ-022 While rst=1, asynchronously, the block SHALL force:
- state = IDLE;
- counter = 0;
- last-grant = if;
- all outputs = 0, including if_rdata and mem_rdata.
REQ-023 Reset asserted during ACCESS SHALL abort the access with sram_ce=0 immediately, and no ready SHALL pulse for the aborted access.
REQ-024 After rst falls, the first grant SHALL be evaluated in the first IDLE cycle.

Verification
REQ-025 WAIT_CYCLES=1, lone if_req, if_addr=0x00000010, sram_rdata=0xDEADBEEF -> sram_addr=0x00004 for 2 cycles; if_ready=1 in cycle 3; if_rdata=0xDEADBEEF; stall_req=1 in cycles 0-2.
REQ-026 Both requests held high, addresses 0x100 (mem) and 0x200 (if) -> grants alternate mem, if, mem; ready pulses never overlap.
REQ-027 mem write, mem_addr=0x00400008, mem_sel=4'b0011, mem_wdata=0x1234ABCD -> sram_addr=0x00002, sram_be=4'b0011, sram_we=1 throughout ACCESS; mem_rdata unchanged.
REQ-028 WAIT_CYCLES=3, rst pulsed in the second ACCESS cycle -> sram_ce drops the same cycle, no ready pulse, all outputs 0; a fresh if_req afterwards completes in 5 cycles.
REQ-029 WAIT_CYCLES=0, mem_req dropped one cycle after grant -> mem_ready still pulses in cycle 2.
